// File: rtl/safebox_lock_ctrl.sv
// SafeBox lock/unlock sequencer: edits a 4-digit BCD entry from button
// pulses, checks it against the stored combination, and walks the safe
// through ENTRY -> CHECK -> OPEN / PROGRAM / LOCKOUT.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_ENTRY   | locked, user edits the entry code
//   ST_CHECK   | one-cycle compare of entry against stored code
//   ST_OPEN    | unlocked, display shows stored code
//   ST_PROGRAM | unlocked, user edits a new code, btn_enter commits it
//   ST_LOCKOUT | too many wrong entries, inputs ignored until timer expires
module safebox_lock_ctrl #(
    parameter logic [15:0] DEFAULT_CODE = 16'h0000,
    parameter int          MAX_FAIL     = 3,
    parameter int          LOCKOUT_CYC  = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_up,
    input  logic        btn_next,
    input  logic        btn_enter,
    input  logic        sw_prog,
    output logic [15:0] disp_bcd,
    output logic [1:0]  cursor,
    output logic        locked,
    output logic        opened,
    output logic        alarm,
    output logic [7:0]  leds
);

    localparam int            TW         = $clog2(LOCKOUT_CYC + 1);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(LOCKOUT_CYC - 1);
    localparam logic [1:0]    FAIL_LIMIT = 2'(MAX_FAIL);

    typedef enum logic [2:0] {
        ST_ENTRY,
        ST_CHECK,
        ST_OPEN,
        ST_PROGRAM,
        ST_LOCKOUT
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   code_q, code_d;
    logic [15:0]   entry_q, entry_d;
    logic [1:0]    cursor_q, cursor_d;
    logic [1:0]    fail_cnt_q, fail_cnt_d;
    logic [TW-1:0] timer_q, timer_d;

    logic [15:0]   disp_q, disp_d;
    logic          locked_q, locked_d;
    logic          opened_q, opened_d;
    logic          alarm_q, alarm_d;
    logic          prog_q, prog_d;

    logic [3:0]    cur_digit;
    logic [15:0]   entry_bump;
    logic [1:0]    fail_inc;

    // Entry with the digit under the cursor incremented modulo 10.
    always_comb begin
        cur_digit  = entry_q[{cursor_q, 2'b00} +: 4];
        entry_bump = entry_q;
        entry_bump[{cursor_q, 2'b00} +: 4] = (cur_digit == 4'd9) ? 4'd0 : cur_digit + 4'd1;
    end

    // Next-state logic; button priority is enter > next > up.
    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        entry_d    = entry_q;
        cursor_d   = cursor_q;
        fail_cnt_d = fail_cnt_q;
        timer_d    = timer_q;
        fail_inc   = fail_cnt_q + 2'd1;
        case (state_q)
            ST_ENTRY: begin
                if (btn_enter) begin
                    state_d = ST_CHECK;
                end else if (btn_next) begin
                    cursor_d = cursor_q + 2'd1;
                end else if (btn_up) begin
                    entry_d = entry_bump;
                end
            end
            ST_CHECK: begin
                entry_d  = 16'h0000;
                cursor_d = 2'd0;
                if (entry_q == code_q) begin
                    state_d    = ST_OPEN;
                    fail_cnt_d = 2'd0;
                end else begin
                    fail_cnt_d = fail_inc;
                    if (fail_inc == FAIL_LIMIT) begin
                        state_d = ST_LOCKOUT;
                        timer_d = TIMER_LOAD;
                    end else begin
                        state_d = ST_ENTRY;
                    end
                end
            end
            ST_OPEN: begin
                if (btn_enter) begin
                    entry_d  = 16'h0000;
                    cursor_d = 2'd0;
                    state_d  = sw_prog ? ST_PROGRAM : ST_ENTRY;
                end
            end
            ST_PROGRAM: begin
                // A commit wins over a simultaneous switch release.
                if (btn_enter) begin
                    code_d  = entry_q;
                    state_d = ST_OPEN;
                end else if (!sw_prog) begin
                    state_d = ST_OPEN;
                end else if (btn_next) begin
                    cursor_d = cursor_q + 2'd1;
                end else if (btn_up) begin
                    entry_d = entry_bump;
                end
            end
            ST_LOCKOUT: begin
                if (timer_q == '0) begin
                    state_d    = ST_ENTRY;
                    fail_cnt_d = 2'd0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = ST_ENTRY;
        endcase
    end

    // Output values decoded from the next state so they land in flops.
    always_comb begin
        locked_d = (state_d == ST_ENTRY) || (state_d == ST_CHECK) || (state_d == ST_LOCKOUT);
        opened_d = (state_d == ST_OPEN) || (state_d == ST_PROGRAM);
        alarm_d  = (state_d == ST_LOCKOUT);
        prog_d   = (state_d == ST_PROGRAM);
        case (state_d)
            ST_ENTRY, ST_PROGRAM: disp_d = entry_d;
            ST_OPEN:              disp_d = code_d;
            default:              disp_d = 16'h0000;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_ENTRY;
            code_q     <= DEFAULT_CODE;
            entry_q    <= 16'h0000;
            cursor_q   <= 2'd0;
            fail_cnt_q <= 2'd0;
            timer_q    <= '0;
            disp_q     <= 16'h0000;
            locked_q   <= 1'b1;
            opened_q   <= 1'b0;
            alarm_q    <= 1'b0;
            prog_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            entry_q    <= entry_d;
            cursor_q   <= cursor_d;
            fail_cnt_q <= fail_cnt_d;
            timer_q    <= timer_d;
            disp_q     <= disp_d;
            locked_q   <= locked_d;
            opened_q   <= opened_d;
            alarm_q    <= alarm_d;
            prog_q     <= prog_d;
        end
    end

    assign disp_bcd = disp_q;
    assign cursor   = cursor_q;
    assign locked   = locked_q;
    assign opened   = opened_q;
    assign alarm    = alarm_q;
    assign leds     = {cursor_q, fail_cnt_q, alarm_q, prog_q, locked_q, opened_q};

endmodule

// File: tb/tb_safebox_lock_ctrl.sv
// Bench for safebox_lock_ctrl: each scenario builds a list of one-cycle
// steps with the expected outputs after that cycle's edge; expectations go
// through a scoreboard queue and are compared one cycle later.
module tb_safebox_lock_ctrl;

    localparam int S_ENTRY = 0, S_CHECK = 1, S_OPEN = 2, S_PROG = 3, S_LOCK = 4;
    localparam int A_IDLE = 0, A_UP = 1, A_NEXT = 2, A_ENTER = 3, A_SETPROG = 4,
                   A_CLRPROG = 5, A_RST = 6, A_ALL = 7, A_NEXT_UP = 8,
                   A_ENTER_CLR = 9, A_RST_UP = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_up = 1'b0, btn_next = 1'b0, btn_enter = 1'b0, sw_prog = 1'b0;
    logic [15:0] disp_bcd;
    logic [1:0]  cursor;
    logic        locked, opened, alarm;
    logic [7:0]  leds;

    typedef struct {
        int          act;
        int          st;
        logic [15:0] disp;
        int          cur;
        int          fail;
    } step_t;

    step_t       steps[$];
    logic [28:0] exp_q[$];
    logic [28:0] obs, e;
    step_t       s;
    int          total = 0;
    int          bad = 0;
    int          idx;

    safebox_lock_ctrl #(
        .DEFAULT_CODE(16'h0000),
        .MAX_FAIL    (3),
        .LOCKOUT_CYC (20)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_up   (btn_up),
        .btn_next (btn_next),
        .btn_enter(btn_enter),
        .sw_prog  (sw_prog),
        .disp_bcd (disp_bcd),
        .cursor   (cursor),
        .locked   (locked),
        .opened   (opened),
        .alarm    (alarm),
        .leds     (leds)
    );

    always #5 clk = ~clk;

    assign obs = {disp_bcd, cursor, locked, opened, alarm, leds};

    function automatic logic [28:0] ev(input int st, input logic [15:0] d, input int cur, input int fail);
        logic lk, op, al, pg;
        lk = (st == S_ENTRY) || (st == S_CHECK) || (st == S_LOCK);
        op = (st == S_OPEN) || (st == S_PROG);
        al = (st == S_LOCK);
        pg = (st == S_PROG);
        return {d, 2'(cur), lk, op, al, 2'(cur), 2'(fail), al, pg, lk, op};
    endfunction

    task automatic add(input int act, input int st, input logic [15:0] d, input int cur, input int fail);
        step_t t;
        t.act = act; t.st = st; t.disp = d; t.cur = cur; t.fail = fail;
        steps.push_back(t);
    endtask

    // Key in a full code starting from entry 0000, cursor 0.
    task automatic add_code(input int st, input logic [15:0] code, input int fail);
        logic [15:0] val;
        int          dig;
        val = 16'h0000;
        for (int d = 0; d < 4; d++) begin
            dig = int'(code[4*d +: 4]);
            for (int k = 1; k <= dig; k++) begin
                val[4*d +: 4] = 4'(k);
                add(A_UP, st, val, d, fail);
            end
            if (d < 3) add(A_NEXT, st, val, d + 1, fail);
        end
    endtask

    // Applies one step's inputs across exactly one rising edge.
    task automatic drive(input int act);
        case (act)
            A_UP:        btn_up = 1'b1;
            A_NEXT:      btn_next = 1'b1;
            A_ENTER:     btn_enter = 1'b1;
            A_SETPROG:   sw_prog = 1'b1;
            A_CLRPROG:   sw_prog = 1'b0;
            A_RST:       rst = 1'b1;
            A_ALL:       begin btn_up = 1'b1; btn_next = 1'b1; btn_enter = 1'b1; end
            A_NEXT_UP:   begin btn_up = 1'b1; btn_next = 1'b1; end
            A_ENTER_CLR: begin btn_enter = 1'b1; sw_prog = 1'b0; end
            A_RST_UP:    begin rst = 1'b1; btn_up = 1'b1; end
            default:     ;
        endcase
        @(posedge clk);
        #1;
        btn_up = 1'b0; btn_next = 1'b0; btn_enter = 1'b0; rst = 1'b0;
    endtask

    task automatic test_reset();
        sw_prog = 1'b0;
        add(A_RST, S_ENTRY, 16'h0000, 0, 0);
        add(A_IDLE, S_ENTRY, 16'h0000, 0, 0);
        idx = 0;
        while (steps.size() > 0) begin
            s = steps.pop_front();
            exp_q.push_back(ev(s.st, s.disp, s.cur, s.fail));
            drive(s.act);
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL reset step %0d: got=%h want=%h", idx, obs, e);
            end
            idx++;
        end
    endtask

    task automatic test_unlock();
        add(A_RST, S_ENTRY, 16'h0000, 0, 0);
        add(A_ENTER, S_CHECK, 16'h0000, 0, 0);
        add(A_IDLE, S_OPEN, 16'h0000, 0, 0);
        add(A_UP, S_OPEN, 16'h0000, 0, 0);
        add(A_ENTER, S_ENTRY, 16'h0000, 0, 0);
        idx = 0;
        while (steps.size() > 0) begin
            s = steps.pop_front();
            exp_q.push_back(ev(s.st, s.disp, s.cur, s.fail));
            drive(s.act);
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL unlock step %0d: got=%h want=%h", idx, obs, e);
            end
            idx++;
        end
    endtask

    task automatic test_edit_wrap();
        add(A_RST, S_ENTRY, 16'h0000, 0, 0);
        for (int i = 1; i <= 10; i++) add(A_UP, S_ENTRY, 16'(i % 10), 0, 0);
        for (int i = 1; i <= 4; i++) add(A_NEXT, S_ENTRY, 16'h0000, i % 4, 0);
        add(A_NEXT, S_ENTRY, 16'h0000, 1, 0);
        add(A_NEXT, S_ENTRY, 16'h0000, 2, 0);
        add(A_UP, S_ENTRY, 16'h0100, 2, 0);
        add(A_UP, S_ENTRY, 16'h0200, 2, 0);
        add(A_UP, S_ENTRY, 16'h0300, 2, 0);
        idx = 0;
        while (steps.size() > 0) begin
            s = steps.pop_front();
            exp_q.push_back(ev(s.st, s.disp, s.cur, s.fail));
            drive(s.act);
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL edit_wrap step %0d: got=%h want=%h", idx, obs, e);
            end
            idx++;
        end
    endtask

    task automatic test_program();
        add(A_RST, S_ENTRY, 16'h0000, 0, 0);
        add(A_ENTER, S_CHECK, 16'h0000, 0, 0);
        add(A_IDLE, S_OPEN, 16'h0000, 0, 0);
        add(A_SETPROG, S_OPEN, 16'h0000, 0, 0);
        add(A_ENTER, S_PROG, 16'h0000, 0, 0);
        add_code(S_PROG, 16'h4321, 0);
        add(A_ENTER, S_OPEN, 16'h4321, 3, 0);
        add(A_CLRPROG, S_OPEN, 16'h4321, 3, 0);
        add(A_ENTER, S_ENTRY, 16'h0000, 0, 0);
        add_code(S_ENTRY, 16'h4321, 0);
        add(A_ENTER, S_CHECK, 16'h0000, 3, 0);
        add(A_IDLE, S_OPEN, 16'h4321, 0, 0);
        add(A_ENTER, S_ENTRY, 16'h0000, 0, 0);
        add(A_ENTER, S_CHECK, 16'h0000, 0, 0);
        add(A_IDLE, S_ENTRY, 16'h0000, 0, 1);
        idx = 0;
        while (steps.size() > 0) begin
            s = steps.pop_front();
            exp_q.push_back(ev(s.st, s.disp, s.cur, s.fail));
            drive(s.act);
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL program step %0d: got=%h want=%h", idx, obs, e);
            end
            idx++;
        end
    endtask

    task automatic test_abort();
        add(A_RST, S_ENTRY, 16'h0000, 0, 0);
        add(A_ENTER, S_CHECK, 16'h0000, 0, 0);
        add(A_IDLE, S_OPEN, 16'h0000, 0, 0);
        add(A_SETPROG, S_OPEN, 16'h0000, 0, 0);
        add(A_ENTER, S_PROG, 16'h0000, 0, 0);
        add_code(S_PROG, 16'h4321, 0);
        add(A_ENTER, S_OPEN, 16'h4321, 3, 0);
        add(A_ENTER, S_PROG, 16'h0000, 0, 0);
        for (int i = 1; i <= 9; i++) add(A_UP, S_PROG, 16'(i), 0, 0);
        add(A_CLRPROG, S_OPEN, 16'h4321, 0, 0);
        add(A_SETPROG, S_OPEN, 16'h4321, 0, 0);
        add(A_ENTER, S_PROG, 16'h0000, 0, 0);
        add(A_UP, S_PROG, 16'h0001, 0, 0);
        add(A_ENTER_CLR, S_OPEN, 16'h0001, 0, 0);
        add(A_ENTER, S_ENTRY, 16'h0000, 0, 0);
        add(A_UP, S_ENTRY, 16'h0001, 0, 0);
        add(A_ENTER, S_CHECK, 16'h0000, 0, 0);
        add(A_IDLE, S_OPEN, 16'h0001, 0, 0);
        idx = 0;
        while (steps.size() > 0) begin
            s = steps.pop_front();
            exp_q.push_back(ev(s.st, s.disp, s.cur, s.fail));
            drive(s.act);
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL abort step %0d: got=%h want=%h", idx, obs, e);
            end
            idx++;
        end
    endtask

    task automatic test_lockout();
        add(A_RST, S_ENTRY, 16'h0000, 0, 0);
        for (int f = 0; f < 3; f++) begin
            add(A_UP, S_ENTRY, 16'h0001, 0, f);
            add(A_ENTER, S_CHECK, 16'h0000, 0, f);
            if (f < 2) add(A_IDLE, S_ENTRY, 16'h0000, 0, f + 1);
            else       add(A_IDLE, S_LOCK, 16'h0000, 0, 3);
        end
        // 19 more cycles held in lockout with buttons hammered, then release
        for (int i = 1; i <= 19; i++) add((i % 3) + 1, S_LOCK, 16'h0000, 0, 3);
        add(A_UP, S_ENTRY, 16'h0000, 0, 0);
        add(A_ENTER, S_CHECK, 16'h0000, 0, 0);
        add(A_IDLE, S_OPEN, 16'h0000, 0, 0);
        idx = 0;
        while (steps.size() > 0) begin
            s = steps.pop_front();
            exp_q.push_back(ev(s.st, s.disp, s.cur, s.fail));
            drive(s.act);
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL lockout step %0d: got=%h want=%h", idx, obs, e);
            end
            idx++;
        end
    endtask

    task automatic test_priority_reset();
        add(A_RST, S_ENTRY, 16'h0000, 0, 0);
        add(A_ALL, S_CHECK, 16'h0000, 0, 0);
        add(A_IDLE, S_OPEN, 16'h0000, 0, 0);
        add(A_ENTER, S_ENTRY, 16'h0000, 0, 0);
        add(A_NEXT_UP, S_ENTRY, 16'h0000, 1, 0);
        add(A_RST, S_ENTRY, 16'h0000, 0, 0);
        add(A_ENTER, S_CHECK, 16'h0000, 0, 0);
        add(A_IDLE, S_OPEN, 16'h0000, 0, 0);
        add(A_SETPROG, S_OPEN, 16'h0000, 0, 0);
        add(A_ENTER, S_PROG, 16'h0000, 0, 0);
        add_code(S_PROG, 16'h4321, 0);
        add(A_ENTER, S_OPEN, 16'h4321, 3, 0);
        add(A_ENTER, S_PROG, 16'h0000, 0, 0);
        add(A_UP, S_PROG, 16'h0001, 0, 0);
        add(A_RST_UP, S_ENTRY, 16'h0000, 0, 0);
        add(A_ENTER, S_CHECK, 16'h0000, 0, 0);
        add(A_IDLE, S_OPEN, 16'h0000, 0, 0);
        idx = 0;
        while (steps.size() > 0) begin
            s = steps.pop_front();
            exp_q.push_back(ev(s.st, s.disp, s.cur, s.fail));
            drive(s.act);
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL priority_reset step %0d: got=%h want=%h", idx, obs, e);
            end
            idx++;
        end
        sw_prog = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_unlock();
        test_edit_wrap();
        test_program();
        test_abort();
        test_lockout();
        test_priority_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
